// File: rtl/lc4_regfile_pkg.sv
// Shared definitions for the dual-write LC4 register file:
// clear-engine state encoding and default geometry.
package lc4_regfile_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } rf_state_t;

   localparam int LC4_WORD  = 16;
   localparam int LC4_NREGS = 8;

endpackage

// File: rtl/Nbit_reg.sv
// Generic n-bit register with load enable, global write enable and
// asynchronous active-high reset to the value r.
module Nbit_reg #(
   parameter int           n = 1,
   parameter logic [n-1:0] r = '0
) (
   input  logic [n-1:0] in,
   output logic [n-1:0] out,
   input  logic         clk,
   input  logic         we,
   input  logic         gwe,
   input  logic         rst
);

   // Load on enabled edges; reset forces the reset value at any time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= r;
      end else if (gwe && we) begin
         out <= in;
      end
   end

endmodule

// File: rtl/lc4_rf_wsel.sv
// Per-register write select: decides whether register idx loads this
// cycle and with what value. The clear engine owns the register while
// running; otherwise port B takes priority over port A on a shared target.
module lc4_rf_wsel #(
   parameter int n  = 16,
   parameter int aw = 3
) (
   input  logic [aw-1:0] idx,
   input  logic          busy,
   input  logic [aw-1:0] clr_idx,
   input  logic          we_a,
   input  logic [aw-1:0] rd_a,
   input  logic [n-1:0]  wdata_a,
   input  logic          we_b,
   input  logic [aw-1:0] rd_b,
   input  logic [n-1:0]  wdata_b,
   output logic          ld,
   output logic [n-1:0]  nxt
);

   logic hit_a;
   logic hit_b;

   assign hit_a = we_a && (rd_a == idx);
   assign hit_b = we_b && (rd_b == idx);

   // Select load enable and next value; clearing suppresses both write ports.
   always_comb begin
      ld  = 1'b0;
      nxt = wdata_a;
      if (busy) begin
         ld  = (clr_idx == idx);
         nxt = '0;
      end else if (hit_b) begin
         ld  = 1'b1;
         nxt = wdata_b;
      end else if (hit_a) begin
         ld  = 1'b1;
         nxt = wdata_a;
      end
   end

endmodule

// File: rtl/lc4_regfile_2w.sv
// Parametrised LC4 register file: two combinational read ports, two write
// ports (B wins on a shared destination) and a sequential clear engine that
// zeroes one register per gwe cycle. Defining LC4_REGFILE_BYPASS_EN forwards
// same-cycle write data to matching read ports while the engine is idle.
module lc4_regfile_2w
   import lc4_regfile_pkg::*;
#(
   parameter int n     = LC4_WORD,
   parameter int nregs = LC4_NREGS,
   parameter int aw    = $clog2(nregs)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          gwe,
   input  logic [aw-1:0] i_rs,
   output logic [n-1:0]  o_rs_data,
   input  logic [aw-1:0] i_rt,
   output logic [n-1:0]  o_rt_data,
   input  logic [aw-1:0] i_rd_a,
   input  logic [n-1:0]  i_wdata_a,
   input  logic          i_we_a,
   input  logic [aw-1:0] i_rd_b,
   input  logic [n-1:0]  i_wdata_b,
   input  logic          i_we_b,
   input  logic          i_clear,
   output logic          o_busy,
   output logic          o_clear_done
);

   rf_state_t       state;
   rf_state_t       state_nxt;
   logic [aw-1:0]   clr_idx;
   logic [aw-1:0]   clr_idx_nxt;
   logic            done_nxt;
   logic            busy;

   logic [n-1:0]     regs [nregs];
   logic [n-1:0]     nxt  [nregs];
   logic [nregs-1:0] ld;

   assign busy   = (state == ST_CLEAR);
   assign o_busy = busy;

   // Clear-engine next state: walk indices 0..nregs-1, then flag completion.
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      done_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_clear) begin
               state_nxt   = ST_CLEAR;
               clr_idx_nxt = '0;
            end
         end
         ST_CLEAR: begin
            if (clr_idx == aw'(nregs - 1)) begin
               state_nxt   = ST_IDLE;
               clr_idx_nxt = '0;
               done_nxt    = 1'b1;
            end else begin
               clr_idx_nxt = clr_idx + aw'(1);
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            clr_idx_nxt = '0;
         end
      endcase
   end

   // Clear-engine state; everything freezes while gwe is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         clr_idx      <= '0;
         o_clear_done <= 1'b0;
      end else if (gwe) begin
         state        <= state_nxt;
         clr_idx      <= clr_idx_nxt;
         o_clear_done <= done_nxt;
      end
   end

   for (genvar g = 0; g < nregs; g++) begin : g_reg
      lc4_rf_wsel #(
         .n  (n),
         .aw (aw)
      ) u_wsel (
         .idx     (aw'(g)),
         .busy    (busy),
         .clr_idx (clr_idx),
         .we_a    (i_we_a),
         .rd_a    (i_rd_a),
         .wdata_a (i_wdata_a),
         .we_b    (i_we_b),
         .rd_b    (i_rd_b),
         .wdata_b (i_wdata_b),
         .ld      (ld[g]),
         .nxt     (nxt[g])
      );

      Nbit_reg #(
         .n (n)
      ) u_reg (
         .in  (nxt[g]),
         .out (regs[g]),
         .clk (clk),
         .we  (ld[g]),
         .gwe (gwe),
         .rst (rst)
      );
   end

   // Read ports: stored contents, optionally overridden by a committing write.
   always_comb begin
      o_rs_data = regs[i_rs];
      o_rt_data = regs[i_rt];
`ifdef LC4_REGFILE_BYPASS_EN
      if (gwe && !busy) begin
         if (i_we_a && (i_rd_a == i_rs)) o_rs_data = i_wdata_a;
         if (i_we_b && (i_rd_b == i_rs)) o_rs_data = i_wdata_b;
         if (i_we_a && (i_rd_a == i_rt)) o_rt_data = i_wdata_a;
         if (i_we_b && (i_rd_b == i_rt)) o_rt_data = i_wdata_b;
      end
`endif
   end

endmodule
